// File: rtl/conv_engine_seq.sv
// Sequential multi-channel 2-D convolution engine.
// Latches NUM_CH ifmaps and filters on start, performs one signed MAC per
// cycle (channel outer, filter row, filter col inner) and streams each output
// pixel in row-major order over a valid/ready port, with optional ReLU.

// Per-channel operand fetch: selects the ifmap element under the current
// window position and the matching filter tap for one channel.
module conv_engine_seq_tap #(
   parameter int W      = 8,
   parameter int IFS    = 5,
   parameter int FS     = 3,
   parameter int STRIDE = 1,
   parameter int RC_W   = 3,
   parameter int FX_W   = 2,
   parameter int IX_W   = 3
) (
   input  logic [IFS-1:0][IFS-1:0][W-1:0] ifmap_ch,
   input  logic [FS-1:0][FS-1:0][W-1:0]   filter_ch,
   input  logic [RC_W-1:0]                row,
   input  logic [RC_W-1:0]                col,
   input  logic [FX_W-1:0]                fr,
   input  logic [FX_W-1:0]                fc,
   output logic [W-1:0]                   pix,
   output logic [W-1:0]                   tap
);

   int ir;
   int ic;

   // window origin scaled by stride, offset by the filter position
   always_comb begin
      ir  = int'(row) * STRIDE + int'(fr);
      ic  = int'(col) * STRIDE + int'(fc);
      pix = ifmap_ch[IX_W'(ir)][IX_W'(ic)];
      tap = filter_ch[fr][fc];
   end

endmodule

module conv_engine_seq #(
   parameter int IP_DATA_WIDTH = 8,
   parameter int IFMAP_SIZE    = 5,
   parameter int FILTER_SIZE   = 3,
   parameter int STRIDE        = 1,
   parameter int NUM_CH        = 2,
   localparam int OFMAP_SIZE   = (IFMAP_SIZE - FILTER_SIZE) / STRIDE + 1,
   localparam int MAC_CNT      = NUM_CH * FILTER_SIZE * FILTER_SIZE,
   localparam int ACC_WIDTH    = 2 * IP_DATA_WIDTH + $clog2(MAC_CNT),
   localparam int RC_W         = $clog2(OFMAP_SIZE) + 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 relu_en,
   input  logic [NUM_CH-1:0][IFMAP_SIZE-1:0][IFMAP_SIZE-1:0][IP_DATA_WIDTH-1:0]   ifmap,
   input  logic [NUM_CH-1:0][FILTER_SIZE-1:0][FILTER_SIZE-1:0][IP_DATA_WIDTH-1:0] filter,
   output logic                 busy,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [ACC_WIDTH-1:0] out_data,
   output logic [RC_W-1:0]      out_row,
   output logic [RC_W-1:0]      out_col,
   output logic                 out_last,
   output logic                 done
);

   localparam int W    = IP_DATA_WIDTH;
   localparam int IX_W = (IFMAP_SIZE  > 1) ? $clog2(IFMAP_SIZE)  : 1;
   localparam int FX_W = (FILTER_SIZE > 1) ? $clog2(FILTER_SIZE) : 1;
   localparam int CH_W = (NUM_CH      > 1) ? $clog2(NUM_CH)      : 1;

   typedef enum logic [1:0] {IDLE, MAC, EMIT, DONE} state_t;

   state_t state, state_nxt;

   // job-private copies, isolated from input changes while running
   logic [NUM_CH-1:0][IFMAP_SIZE-1:0][IFMAP_SIZE-1:0][W-1:0]   ifmap_q;
   logic [NUM_CH-1:0][FILTER_SIZE-1:0][FILTER_SIZE-1:0][W-1:0] filter_q;
   logic                                                       relu_q;

   // MAC position within the current pixel and the pixel being computed
   logic [CH_W-1:0] ch;
   logic [FX_W-1:0] fr, fc;
   logic [RC_W-1:0] row, col;

   logic signed [ACC_WIDTH-1:0] acc;

   logic [NUM_CH-1:0][W-1:0] lane_pix;
   logic [NUM_CH-1:0][W-1:0] lane_tap;

   logic signed [2*W-1:0]       pix_s, tap_s, prod;
   logic signed [ACC_WIDTH-1:0] prod_ext, acc_sum;
   logic                        mac_last, pix_last, hs;

   genvar g;
   generate
      for (g = 0; g < NUM_CH; g++) begin : g_lane
         conv_engine_seq_tap #(
            .W(W), .IFS(IFMAP_SIZE), .FS(FILTER_SIZE), .STRIDE(STRIDE),
            .RC_W(RC_W), .FX_W(FX_W), .IX_W(IX_W)
         ) u_tap (
            .ifmap_ch (ifmap_q[g]),
            .filter_ch(filter_q[g]),
            .row      (row),
            .col      (col),
            .fr       (fr),
            .fc       (fc),
            .pix      (lane_pix[g]),
            .tap      (lane_tap[g])
         );
      end
   endgenerate

   // product of the selected channel's operands, widened to the accumulator
   always_comb begin
      pix_s    = {{W{lane_pix[ch][W-1]}}, lane_pix[ch]};
      tap_s    = {{W{lane_tap[ch][W-1]}}, lane_tap[ch]};
      prod     = pix_s * tap_s;
      prod_ext = {{(ACC_WIDTH-2*W){prod[2*W-1]}}, prod};
      acc_sum  = acc + prod_ext;
      mac_last = (ch == CH_W'(NUM_CH-1)) && (fr == FX_W'(FILTER_SIZE-1)) &&
                 (fc == FX_W'(FILTER_SIZE-1));
      pix_last = (row == RC_W'(OFMAP_SIZE-1)) && (col == RC_W'(OFMAP_SIZE-1));
      hs       = out_valid && out_ready;
   end

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // next-state: accumulate, present, advance or finish
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (start)    state_nxt = MAC;
         MAC:  if (mac_last) state_nxt = EMIT;
         EMIT: if (out_ready) state_nxt = pix_last ? DONE : MAC;
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign busy      = (state != IDLE);
   assign out_valid = (state == EMIT);
   assign done      = (state == DONE);

   // capture, MAC sequencing and output pixel registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ifmap_q  <= '0;
         filter_q <= '0;
         relu_q   <= 1'b0;
         ch       <= '0;
         fr       <= '0;
         fc       <= '0;
         row      <= '0;
         col      <= '0;
         acc      <= '0;
         out_data <= '0;
         out_row  <= '0;
         out_col  <= '0;
         out_last <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  ifmap_q  <= ifmap;
                  filter_q <= filter;
                  relu_q   <= relu_en;
                  ch       <= '0;
                  fr       <= '0;
                  fc       <= '0;
                  row      <= '0;
                  col      <= '0;
                  acc      <= '0;
               end
            end
            MAC: begin
               acc <= acc_sum;
               if (fc == FX_W'(FILTER_SIZE-1)) begin
                  fc <= '0;
                  if (fr == FX_W'(FILTER_SIZE-1)) begin
                     fr <= '0;
                     if (ch == CH_W'(NUM_CH-1)) ch <= '0;
                     else                       ch <= ch + 1'b1;
                  end else begin
                     fr <= fr + 1'b1;
                  end
               end else begin
                  fc <= fc + 1'b1;
               end
               // the final product folds straight into the presented result
               if (mac_last) begin
                  out_data <= (relu_q && acc_sum[ACC_WIDTH-1]) ? '0 : acc_sum;
                  out_row  <= row;
                  out_col  <= col;
                  out_last <= pix_last;
               end
            end
            EMIT: begin
               if (hs) begin
                  acc      <= '0;
                  out_last <= 1'b0;
                  if (pix_last) begin
                     row <= '0;
                     col <= '0;
                  end else if (col == RC_W'(OFMAP_SIZE-1)) begin
                     col <= '0;
                     row <= row + 1'b1;
                  end else begin
                     col <= col + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_conv_engine_seq.sv
// Bench for conv_engine_seq: directed and random jobs checked per cycle
// against a plain nested-loop convolution model.
module tb_conv_engine_seq;

   localparam int W    = 8;
   localparam int IFS  = 5;
   localparam int FS   = 3;
   localparam int S    = 1;
   localparam int NC   = 2;
   localparam int OF   = (IFS - FS) / S + 1;
   localparam int MC   = NC * FS * FS;
   localparam int AW   = 2 * W + $clog2(MC);
   localparam int RCW  = $clog2(OF) + 1;
   localparam int NPIX = OF * OF;

   logic clk = 1'b0;
   logic rst_n, start, relu_en, out_ready;
   logic [NC-1:0][IFS-1:0][IFS-1:0][W-1:0] ifmap;
   logic [NC-1:0][FS-1:0][FS-1:0][W-1:0]   filter;
   logic busy, out_valid, out_last, done;
   logic [AW-1:0]  out_data;
   logic [RCW-1:0] out_row, out_col;

   conv_engine_seq dut (
      .clk(clk), .rst_n(rst_n), .start(start), .relu_en(relu_en),
      .ifmap(ifmap), .filter(filter), .busy(busy), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_row(out_row),
      .out_col(out_col), .out_last(out_last), .done(done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   int m_if [NC][IFS][IFS];
   int m_f  [NC][FS][FS];
   int exp_px [NPIX];

   longint cyc = 0;
   int  pix_idx = 0;
   int  first_v_cyc = -1;
   int  done_cyc = -1;
   int  stall_left = 0;
   int  stall_seen = 0;
   int  ready_mode = 0;
   bit  mon_en = 0;
   bit  last_hs = 0;
   bit  prev_stall = 0;
   logic [AW-1:0]  sv_data;
   logic [RCW-1:0] sv_row, sv_col;
   logic           sv_last;

   task automatic chk(input bit ok, input string name, input longint act, input longint expv);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, expv);
      end
   endtask

   // reference: direct convolution over all channels, then optional ReLU
   task automatic model(input bit relu);
      for (int r = 0; r < OF; r++)
         for (int q = 0; q < OF; q++) begin
            int s = 0;
            for (int c = 0; c < NC; c++)
               for (int i = 0; i < FS; i++)
                  for (int j = 0; j < FS; j++)
                     s += m_if[c][r*S+i][q*S+j] * m_f[c][i][j];
            if (relu && s < 0) s = 0;
            exp_px[r*OF+q] = s;
         end
   endtask

   task automatic drive_maps();
      for (int c = 0; c < NC; c++) begin
         for (int i = 0; i < IFS; i++)
            for (int j = 0; j < IFS; j++) ifmap[c][i][j] = m_if[c][i][j][W-1:0];
         for (int i = 0; i < FS; i++)
            for (int j = 0; j < FS; j++) filter[c][i][j] = m_f[c][i][j][W-1:0];
      end
   endtask

   task automatic fill(input int fv, input int wv);
      for (int c = 0; c < NC; c++) begin
         for (int i = 0; i < IFS; i++)
            for (int j = 0; j < IFS; j++) m_if[c][i][j] = fv;
         for (int i = 0; i < FS; i++)
            for (int j = 0; j < FS; j++) m_f[c][i][j] = wv;
      end
   endtask

   task automatic fill_rand();
      for (int c = 0; c < NC; c++) begin
         for (int i = 0; i < IFS; i++)
            for (int j = 0; j < IFS; j++) m_if[c][i][j] = int'($urandom_range(0, 255)) - 128;
         for (int i = 0; i < FS; i++)
            for (int j = 0; j < FS; j++) m_f[c][i][j] = int'($urandom_range(0, 255)) - 128;
      end
   endtask

   // cycle counter
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // downstream ready: always, stall pixel index 2 for 5 cycles, or random
   initial forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
         1: if (out_valid && pix_idx == 2 && stall_left > 0) begin
               out_ready = 1'b0;
               stall_left--;
            end else out_ready = 1'b1;
         2: out_ready = 1'($urandom_range(0, 1));
         default: out_ready = 1'b1;
      endcase
   end

   // per-cycle output checker
   initial forever begin
      @(negedge clk);
      if (!rst_n) begin
         prev_stall = 0;
         last_hs = 0;
      end else if (mon_en) begin
         chk(done == last_hs, "done_timing", longint'(done), longint'(last_hs));
         if (done && done_cyc < 0) done_cyc = int'(cyc);
         last_hs = 0;
         if (prev_stall)
            chk(out_valid && out_data == sv_data && out_row == sv_row &&
                out_col == sv_col && out_last == sv_last, "stall_stable",
                $signed(out_data), $signed(sv_data));
         if (out_valid) begin
            if (first_v_cyc < 0) first_v_cyc = int'(cyc);
            if (pix_idx >= NPIX) chk(1'b0, "extra_pixel", pix_idx, NPIX - 1);
            else begin
               logic [AW-1:0] e;
               e = AW'(exp_px[pix_idx]);
               chk(out_data == e, "pix_data", $signed(out_data), exp_px[pix_idx]);
               chk(int'(out_row) == pix_idx / OF, "pix_row", out_row, pix_idx / OF);
               chk(int'(out_col) == pix_idx % OF, "pix_col", out_col, pix_idx % OF);
               chk(out_last == (pix_idx == NPIX - 1), "pix_last", out_last, pix_idx == NPIX - 1);
               if (out_ready) begin
                  last_hs = (pix_idx == NPIX - 1);
                  pix_idx++;
               end else stall_seen++;
            end
         end
         prev_stall = out_valid && !out_ready;
         sv_data = out_data;
         sv_row  = out_row;
         sv_col  = out_col;
         sv_last = out_last;
      end
   end

   task automatic begin_job(input bit relu, input int mode, output int e0);
      model(relu);
      drive_maps();
      relu_en = relu;
      pix_idx = 0;
      first_v_cyc = -1;
      done_cyc = -1;
      stall_left = 5;
      stall_seen = 0;
      ready_mode = mode;
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1;
      e0 = int'(cyc);
      start = 1'b0;
      chk(busy == 1'b1, "busy_after_start", busy, 1);
   endtask

   task automatic run_job(input bit relu, input int mode, input bit disturb);
      int e0;
      begin_job(relu, mode, e0);
      if (disturb) begin
         repeat (30) @(posedge clk);
         #1;
         fill_rand();
         drive_maps();
         relu_en = ~relu;
         start = 1'b1;
         @(posedge clk);
         #1 start = 1'b0;
      end
      for (int k = 0; k < 3000 && done_cyc < 0; k++) @(posedge clk);
      chk(done_cyc >= 0, "done_timeout", done_cyc, 0);
      chk(pix_idx == NPIX, "pixel_count", pix_idx, NPIX);
      if (mode != 2) begin
         chk(first_v_cyc - e0 == MC, "first_valid_latency", first_v_cyc - e0, MC);
         chk(done_cyc - e0 == NPIX * (MC + 1) + stall_seen, "job_length",
             done_cyc - e0, NPIX * (MC + 1) + stall_seen);
      end
      if (mode == 1) chk(stall_seen == 5, "stall_cycles", stall_seen, 5);
      #1;
      chk(busy == 1'b0 && done == 1'b0, "idle_after_done", busy, 0);
   endtask

   initial begin
      int e0;
      rst_n = 1'b0;
      start = 1'b0;
      relu_en = 1'b0;
      out_ready = 1'b1;
      fill(0, 0);
      drive_maps();
      #12;
      chk(busy == 0,      "rst_busy",      busy, 0);
      chk(out_valid == 0, "rst_out_valid", out_valid, 0);
      chk(out_last == 0,  "rst_out_last",  out_last, 0);
      chk(done == 0,      "rst_done",      done, 0);
      chk(out_data == 0,  "rst_out_data",  out_data, 0);
      chk(out_row == 0 && out_col == 0, "rst_row_col", out_row, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      mon_en = 1;

      // all ones
      fill(1, 1);
      model(0);
      chk(exp_px[0] == 18 && exp_px[8] == 18, "model_ones", exp_px[0], 18);
      run_job(0, 0, 0);

      // ramp ifmap, ch0 centre tap only
      for (int c = 0; c < NC; c++)
         for (int i = 0; i < IFS; i++)
            for (int j = 0; j < IFS; j++) m_if[c][i][j] = i * 5 + j;
      for (int c = 0; c < NC; c++)
         for (int i = 0; i < FS; i++)
            for (int j = 0; j < FS; j++) m_f[c][i][j] = 0;
      m_f[0][1][1] = 1;
      model(0);
      chk(exp_px[0] == 6 && exp_px[3] == 11 && exp_px[8] == 18, "model_ramp", exp_px[3], 11);
      run_job(0, 0, 0);

      // negative results with and without ReLU
      fill(1, -1);
      model(0);
      chk(exp_px[4] == -18, "model_neg", exp_px[4], -18);
      run_job(0, 0, 0);
      model(1);
      chk(exp_px[4] == 0, "model_relu", exp_px[4], 0);
      run_job(1, 0, 0);

      // extreme magnitude
      fill(-128, -128);
      model(0);
      chk(exp_px[0] == 294912, "model_max", exp_px[0], 294912);
      run_job(0, 0, 0);

      // stall on pixel 3 plus ignored start / input changes mid-job
      fill_rand();
      run_job(0, 1, 1);

      // reset during pixel 4 MAC
      fill(1, 1);
      begin_job(0, 0, e0);
      for (int k = 0; k < 500 && pix_idx < 3; k++) @(posedge clk);
      repeat (5) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk(busy == 0 && out_valid == 0 && done == 0 && out_last == 0, "midrst_ctrl", busy, 0);
      chk(out_data == 0 && out_row == 0 && out_col == 0, "midrst_data", out_data, 0);
      repeat (3) @(posedge clk);
      #1 chk(done == 0 && out_valid == 0, "midrst_quiet", done, 0);
      rst_n = 1'b1;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         chk(done == 0 && out_valid == 0, "post_rst_quiet", out_valid, 0);
      end
      fill(1, 1);
      run_job(0, 0, 0);

      // random jobs with random backpressure
      for (int t = 0; t < 6; t++) begin
         fill_rand();
         run_job(1'($urandom_range(0, 1)), 2, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout actual=%0d expected=%0d", cyc, 0);
      $fatal(1);
   end

endmodule
